// File: rtl/neuro_pkg.sv
// Shared FP32 definitions and activation helpers for the neurosynapse datapath.
package neuro_pkg;

  localparam int unsigned FP32_SIGN_BIT = 31;
  localparam int unsigned FP32_EXP_MSB  = 30;
  localparam int unsigned FP32_EXP_LSB  = 23;
  localparam int unsigned FP32_MAN_MSB  = 22;
  localparam int unsigned FP32_MAN_LSB  = 0;

  localparam logic [31:0] FP32_POS_ZERO     = 32'h0000_0000;
  localparam logic [7:0]  FP32_EXP_ALL_ONES = 8'hFF;

  // NaNs keep their payload; every other negative encoding clamps to +0.
  function automatic logic [31:0] relu_fp32(input logic [31:0] v);
    logic is_nan;
    is_nan = (v[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALL_ONES) &&
             (v[FP32_MAN_MSB:FP32_MAN_LSB] != '0);
    if (is_nan)
      return v;
    else if (v[FP32_SIGN_BIT])
      return FP32_POS_ZERO;
    else
      return v;
  endfunction

endpackage

// File: rtl/relu_result_buffer_if.sv
// Upstream and downstream STB/BUSY handshake bundle of the ReLU result buffer.
interface relu_result_buffer_if;

  logic [31:0] input_result;
  logic        relu_input_STB;
  logic        relu_BUSY;
  logic [31:0] output_act;
  logic        relu_output_STB;
  logic        output_module_BUSY;

  modport master (
    output input_result, relu_input_STB, output_module_BUSY,
    input  relu_BUSY, output_act, relu_output_STB
  );

  modport slave (
    input  input_result, relu_input_STB, output_module_BUSY,
    output relu_BUSY, output_act, relu_output_STB
  );

endinterface

// File: rtl/sync_fifo_hs.sv
// Generic synchronous FIFO with STB/BUSY handshakes on both sides.
module sync_fifo_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_stb,
  output logic             wr_busy,
  output logic             wr_fire,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_stb,
  input  logic             rd_busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;

  assign wr_busy = (count == CW'(DEPTH));
  assign rd_stb  = (count != '0);
  assign wr_fire = wr_stb && !wr_busy;
  assign pop     = rd_stb && !rd_busy;
  // Head is forced to zero while empty so reset presents a clean output.
  assign rd_data = rd_stb ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({wr_fire, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/relu_result_buffer.sv
// ReLU activation on the write path of a STB/BUSY FIFO, plus a saturating result counter.
module relu_result_buffer
  import neuro_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  relu_result_buffer_if.slave  bus,
  output logic [15:0]          result_count
);

  logic [31:0] act_in;
  logic        push;
  logic [15:0] rc_q;

  assign act_in = RELU_EN ? relu_fp32(bus.input_result) : bus.input_result;

  sync_fifo_hs #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_data (act_in),
    .wr_stb  (bus.relu_input_STB),
    .wr_busy (bus.relu_BUSY),
    .wr_fire (push),
    .rd_data (bus.output_act),
    .rd_stb  (bus.relu_output_STB),
    .rd_busy (bus.output_module_BUSY)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rc_q <= '0;
    else if (push && (rc_q != '1))
      rc_q <= rc_q + 16'd1;
  end

  assign result_count = rc_q;

endmodule

// File: tb/tb_relu_result_buffer.sv
// Directed plus randomized bench for relu_result_buffer against a queue-based model.
module tb_relu_result_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] rc1, rc0;

  relu_result_buffer_if bus ();
  relu_result_buffer_if bus0 ();

  assign bus0.input_result       = bus.input_result;
  assign bus0.relu_input_STB     = bus.relu_input_STB;
  assign bus0.output_module_BUSY = bus.output_module_BUSY;

  relu_result_buffer #(.DEPTH(DEPTH), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .result_count(rc1)
  );

  relu_result_buffer #(.DEPTH(DEPTH), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .result_count(rc0)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [15:0] rc = '0;
  bit          last_push = 1'b0;

  // ReLU expressed through the number's classification.
  function automatic logic [31:0] ref_relu(input logic [31:0] v);
    bit is_nan, negative;
    is_nan   = (v[30:23] == 8'd255) && (v[22:0] != 0);
    negative = v[31];
    if (!is_nan && negative) return 32'd0;
    return v;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'hFF;
      1: r = 32'h8000_0000;
      2: r = {1'b1, 8'hFF, 23'd0};
      3: r[31] = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("busy",      {31'd0, bus.relu_BUSY},        {31'd0, q1.size() == DEPTH});
    chk("stb",       {31'd0, bus.relu_output_STB},  {31'd0, q1.size() != 0});
    chk("busy0",     {31'd0, bus0.relu_BUSY},       {31'd0, q0.size() == DEPTH});
    chk("stb0",      {31'd0, bus0.relu_output_STB}, {31'd0, q0.size() != 0});
    if (q1.size() != 0) chk("act",  bus.output_act,  q1[0]);
    if (q0.size() != 0) chk("act0", bus0.output_act, q0[0]);
    chk("count",  {16'd0, rc1}, {16'd0, rc});
    chk("count0", {16'd0, rc0}, {16'd0, rc});
  endtask

  task automatic tick();
    bit push, pop;
    @(posedge clk);
    push = bus.relu_input_STB && (q1.size() < DEPTH);
    pop  = (q1.size() != 0) && !bus.output_module_BUSY;
    if (pop) begin
      void'(q1.pop_front());
      void'(q0.pop_front());
    end
    if (push) begin
      q1.push_back(ref_relu(bus.input_result));
      q0.push_back(bus.input_result);
      if (rc != 16'hFFFF) rc = rc + 16'd1;
    end
    last_push = push;
    #1;
    compare_all();
  endtask

  task automatic push_val(input logic [31:0] v);
    bit done;
    done = 1'b0;
    bus.input_result   = v;
    bus.relu_input_STB = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = last_push;
    end
    if (!done) chk("push_timeout", 32'd0, 32'd1);
    bus.relu_input_STB = 1'b0;
  endtask

  task automatic drain();
    bus.relu_input_STB     = 1'b0;
    bus.output_module_BUSY = 1'b0;
    repeat (DEPTH + 2) tick();
    chk("drained", {31'd0, bus.relu_output_STB}, 32'd0);
  endtask

  initial begin
    bus.input_result       = '0;
    bus.relu_input_STB     = 1'b0;
    bus.output_module_BUSY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_act", bus.output_act, 32'd0);
    compare_all();
    rst = 1'b1;

    // 1: single value through an idle buffer
    push_val(32'h4040_0000);
    chk("t1_act", bus.output_act, 32'h4040_0000);
    tick();
    chk("t1_stb_low", {31'd0, bus.relu_output_STB}, 32'd0);
    chk("t1_count", {16'd0, rc1}, 32'd1);

    // 2: negative, -0, -inf and NaN encodings
    push_val(32'hC000_0000);
    push_val(32'h8000_0000);
    push_val(32'hFF80_0000);
    push_val(32'hFFC0_0000);
    drain();

    // 3: fill while downstream is busy, hold a fifth value
    bus.output_module_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) push_val(rand_fp());
    chk("t3_full", {31'd0, bus.relu_BUSY}, 32'd1);
    bus.input_result   = 32'h4120_0000;
    bus.relu_input_STB = 1'b1;
    repeat (2) tick();
    chk("t3_held", {16'd0, rc1}, {16'd0, rc});
    bus.output_module_BUSY = 1'b0;
    tick();
    chk("t3_no_bypass", {31'd0, last_push}, 32'd0);
    tick();
    chk("t3_accept", {31'd0, last_push}, 32'd1);
    drain();

    // 4: simultaneous push/pop at count 2 across pointer wrap
    bus.output_module_BUSY = 1'b1;
    push_val(rand_fp());
    push_val(rand_fp());
    bus.output_module_BUSY = 1'b0;
    bus.relu_input_STB     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.input_result = rand_fp();
      tick();
      chk("t4_busy", {31'd0, bus.relu_BUSY}, 32'd0);
      chk("t4_level", q1.size(), 32'd2);
    end
    drain();

    // 5: asynchronous reset with three entries buffered
    bus.output_module_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) push_val(rand_fp());
    #3;
    rst = 1'b0;
    #1;
    q1.delete();
    q0.delete();
    rc = '0;
    chk("t5_act", bus.output_act, 32'd0);
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.output_module_BUSY = 1'b0;
    push_val(32'h3F80_0000);
    chk("t5_act_after", bus.output_act, 32'h3F80_0000);
    drain();

    // 6: counter saturation
    force dut.rc_q = 16'hFFFE;
    force dut0.rc_q = 16'hFFFE;
    #1;
    release dut.rc_q;
    release dut0.rc_q;
    rc = 16'hFFFE;
    for (int i = 0; i < 3; i++) push_val(rand_fp());
    chk("t6_sat", {16'd0, rc1}, 32'h0000_FFFF);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!bus.relu_input_STB || last_push) begin
        bus.relu_input_STB = 1'($urandom_range(0, 1));
        bus.input_result   = rand_fp();
      end
      bus.output_module_BUSY = ($urandom_range(0, 9) < 3);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_result_buffer.md
Name: relu_result_buffer

Overview:
- Stage directly downstream of the two-product-sum operation unit in the neurosynapse datapath; consumes its FP32 result over the STB/BUSY handshake.
- Applies a ReLU activation on the IEEE-754 single-precision sign bit.
- Buffers activated results in a small FIFO so the operation unit is not stalled by a slow consumer (RoCC response path).
- Presents results downstream over the same STB/BUSY handshake.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
RELU_EN, 1, 1 = apply ReLU; 0 = pass data unchanged.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low.
input_result  input  32  FP32 result from the operation unit.
relu_input_STB  input  1  upstream strobe; input_result valid while high.
relu_BUSY  output  1  high = cannot accept; equals FIFO full.
output_act  output  32  FP32 activated value at the FIFO head.
relu_output_STB  output  1  high = output_act valid; equals FIFO not empty.
output_module_BUSY  input  1  downstream busy; transfer when low and relu_output_STB high.
result_count  output  16  saturating count of results accepted since reset.

Behaviour:
- Reset (rst low, asynchronous): pointers = 0, count = 0, relu_BUSY = 0, relu_output_STB = 0, output_act = 0, result_count = 0. FIFO storage is not cleared.
- Reset mid-operation discards buffered entries. After release, the first accepted value is the next one presented.
- Push: on a rising edge where relu_input_STB && !relu_BUSY. The activated value is written at wr_ptr, wr_ptr increments (wraps modulo DEPTH), and count increments.
- Pop: on a rising edge where relu_output_STB && !output_module_BUSY. rd_ptr increments (wraps modulo DEPTH) and count decrements.
- Push and pop on the same edge: both occur and count is unchanged. Legal at any 0 < count < DEPTH.
- No full bypass: when full, relu_BUSY = 1, so no push is possible that cycle even if a pop occurs.
- No empty bypass: a value pushed into an empty FIFO is not visible on output_act until the next cycle.
- Latency: a value pushed at edge N sets relu_output_STB high and drives output_act in the cycle after edge N (1 cycle).
- relu_BUSY and relu_output_STB decode combinationally from the registered count. No combinational path from input STB to output STB.
- output_act = storage[rd_ptr]. Its value is don't-care when relu_output_STB is low.
- ReLU, applied at write time, when RELU_EN = 1:
  - NaN (exp = 0xFF, mantissa != 0): passed unchanged.
  - Otherwise, sign = 1 (including -0, negative denormals, -inf): written as 0x00000000.
  - Otherwise: passed unchanged.
- result_count increments by 1 per push and saturates at 0xFFFF.
- Holding relu_input_STB while relu_BUSY is high is legal. The value is accepted on the first edge where relu_BUSY is low. Upstream holds the data stable while its strobe is high.
- Pointer width = log2(DEPTH). Count width = log2(DEPTH)+1.

Decomposition:
- Shared package (neuro_pkg):
  - FP32 field constants: sign bit 31, exponent [30:23], mantissa [22:0].
  - FP32_POS_ZERO = 32'h0000_0000.
  - FP32_EXP_ALL_ONES = 8'hFF.
  - A relu_fp32 function, reusable by later activation stages.
- Sub-module: sync_fifo_hs, a generic parameterised FIFO with STB/BUSY on both sides. relu_result_buffer wraps it with the ReLU function on the write path and the result counter.

Test Plan:
1. Reset, then push 0x40400000 (3.0) with output_module_BUSY = 0 -> relu_output_STB high next cycle with output_act = 0x40400000; low the cycle after the pop; result_count = 1.
2. Push 0xC0000000, 0x80000000, 0xFF800000, 0xFFC00000 -> outputs in order: 0x00000000, 0x00000000, 0x00000000, 0xFFC00000. With RELU_EN = 0, all four pass unchanged.
3. Hold output_module_BUSY = 1 and push 4 values -> relu_BUSY = 1 after the 4th push; a 5th value held on the input is not accepted. Release -> 5th accepted one cycle after the first pop; all 5 emerge in FIFO order.
4. At count = 2, push and pop on the same edge for 6 consecutive cycles -> count stays 2 and relu_BUSY stays 0; ordering correct across pointer wrap-around.
5. Assert rst low asynchronously (between edges) with 3 entries buffered -> relu_output_STB, relu_BUSY and result_count are 0 immediately. After release, push 0x3F800000 -> output 0x3F800000.
6. Force result_count to 0xFFFE and push 3 values -> result_count = 0xFFFF and holds there.
